// File: rtl/bus_sequencer.sv
// -----------------------------------------------------------------------------
// bus_sequencer
// Control-step sequencer for the mini CPU's shared 32-bit datapath bus.
// Walks instruction fetch (T0..T2) and register-register ALU execution
// (T3..T6) as fixed T-steps. It drives every bus-source enable and the
// matching load enables, and at most one bus source is active in any cycle.
//
// Ports
//   clock       rising-edge clock
//   clear       asynchronous active-low reset
//   start       begin one instruction (sampled in IDLE only)
//   ir[31:0]    instruction word: opcode=ir[31:27] ra=ir[26:23] rb=ir[22:19] rc=ir[18:15]
//   mem_ready   memory read data valid at the MDR input
//   r_out/r_in  one-hot register bus-source / load enables (bit n = Rn)
//   *_out       remaining bus-source enables (inport_out reserved, tied 0)
//   *_in        remaining load enables
//   inc_pc      ALU computes PC+1 into Z
//   read        memory read strobe
//   alu_op      ADD=0 SUB=1 AND=2 OR=3 MUL=4 DIV=5, 0 outside T0/T4
//   busy        high in every state except IDLE
//   done        one-cycle completion pulse
//   fault       sticky until next accepted start: 00 none, 01 illegal, 10 mem timeout
// -----------------------------------------------------------------------------
module bus_sequencer #(
  parameter int OPW          = 5,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic [15:0] r_out,
  output logic        hi_out,
  output logic        lo_out,
  output logic        zhigh_out,
  output logic        zlow_out,
  output logic        pc_out,
  output logic        mdr_out,
  output logic        inport_out,
  output logic        y_out,
  output logic [15:0] r_in,
  output logic        hi_in,
  output logic        lo_in,
  output logic        y_in,
  output logic        z_in,
  output logic        pc_in,
  output logic        ir_in,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        inc_pc,
  output logic        read,
  output logic [3:0]  alu_op,
  output logic        busy,
  output logic        done,
  output logic [1:0]  fault
);

  localparam int WW = $clog2(MEM_WAIT_MAX + 1);

  localparam logic [OPW-1:0] OP_ADD = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_SUB = OPW'(5'b00100);
  localparam logic [OPW-1:0] OP_AND = OPW'(5'b00101);
  localparam logic [OPW-1:0] OP_OR  = OPW'(5'b00110);
  localparam logic [OPW-1:0] OP_MUL = OPW'(5'b01111);
  localparam logic [OPW-1:0] OP_DIV = OPW'(5'b10000);

  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_ILLEGAL = 2'b01;
  localparam logic [1:0] FLT_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_DONE = 4'd8
  } state_t;

  function automatic logic f_legal(input logic [OPW-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_DIV: f_legal = 1'b1;
      default:                                       f_legal = 1'b0;
    endcase
  endfunction

  function automatic logic f_muldiv(input logic [OPW-1:0] op);
    f_muldiv = (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic [3:0] f_alu(input logic [OPW-1:0] op);
    case (op)
      OP_ADD:  f_alu = 4'd0;
      OP_SUB:  f_alu = 4'd1;
      OP_AND:  f_alu = 4'd2;
      OP_OR:   f_alu = 4'd3;
      OP_MUL:  f_alu = 4'd4;
      OP_DIV:  f_alu = 4'd5;
      default: f_alu = 4'd0;
    endcase
  endfunction

  function automatic logic [15:0] f_onehot(input logic [3:0] idx);
    f_onehot = 16'h0001 << idx;
  endfunction

  state_t         r_state;
  state_t         w_next_state;
  logic [OPW-1:0] r_opcode;
  logic [3:0]     r_ra;
  logic [3:0]     r_rb;
  logic [3:0]     r_rc;
  logic [WW-1:0]  r_wait;
  logic [WW-1:0]  w_wait_next;
  logic [1:0]     r_fault;
  logic [1:0]     w_fault_next;
  logic           w_latch;

  // Low instruction bits carry no register field; folded here on purpose.
  logic           w_unused_ir;
  assign w_unused_ir = &{1'b0, ir[14:0]};

  // The instruction word is captured on the T2->T3 edge so that every
  // T3 output is decoded from registered fields only.
  assign w_latch = (r_state == S_T2);

  // State, wait counter and sticky fault registers.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state <= S_IDLE;
      r_wait  <= '0;
      r_fault <= FLT_NONE;
    end else begin
      r_state <= w_next_state;
      r_wait  <= w_wait_next;
      r_fault <= w_fault_next;
    end
  end

  // Decode latches for opcode and register fields.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_opcode <= '0;
      r_ra     <= 4'd0;
      r_rb     <= 4'd0;
      r_rc     <= 4'd0;
    end else if (w_latch) begin
      r_opcode <= ir[31 -: OPW];
      r_ra     <= ir[26:23];
      r_rb     <= ir[22:19];
      r_rc     <= ir[18:15];
    end else begin
      r_opcode <= r_opcode;
      r_ra     <= r_ra;
      r_rb     <= r_rb;
      r_rc     <= r_rc;
    end
  end

  // Next-state, wait-counter and fault update.
  always_comb begin
    w_next_state = r_state;
    w_wait_next  = '0;
    w_fault_next = r_fault;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_T0;
          w_fault_next = FLT_NONE;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_T0: w_next_state = S_T1;
      S_T1: begin
        if (mem_ready) begin
          w_next_state = S_T2;
        end else if (r_wait == WW'(MEM_WAIT_MAX - 1)) begin
          // This cycle is the MEM_WAIT_MAX-th spent waiting in T1.
          w_next_state = S_DONE;
          w_fault_next = FLT_TIMEOUT;
        end else begin
          w_next_state = S_T1;
          w_wait_next  = r_wait + WW'(1);
        end
      end
      S_T2: w_next_state = S_T3;
      S_T3: begin
        if (f_legal(r_opcode)) begin
          w_next_state = S_T4;
        end else begin
          w_next_state = S_DONE;
          w_fault_next = FLT_ILLEGAL;
        end
      end
      S_T4: w_next_state = S_T5;
      S_T5: begin
        if (f_muldiv(r_opcode)) begin
          w_next_state = S_T6;
        end else begin
          w_next_state = S_DONE;
        end
      end
      S_T6:    w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Per-state output decode; exactly one bus source in each of T0..T6.
  always_comb begin
    r_out      = 16'h0000;
    hi_out     = 1'b0;
    lo_out     = 1'b0;
    zhigh_out  = 1'b0;
    zlow_out   = 1'b0;
    pc_out     = 1'b0;
    mdr_out    = 1'b0;
    inport_out = 1'b0;
    y_out      = 1'b0;
    r_in       = 16'h0000;
    hi_in      = 1'b0;
    lo_in      = 1'b0;
    y_in       = 1'b0;
    z_in       = 1'b0;
    pc_in      = 1'b0;
    ir_in      = 1'b0;
    mar_in     = 1'b0;
    mdr_in     = 1'b0;
    inc_pc     = 1'b0;
    read       = 1'b0;
    alu_op     = 4'd0;
    busy       = 1'b1;
    done       = 1'b0;
    fault      = r_fault;
    case (r_state)
      S_IDLE: busy = 1'b0;
      S_T0: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        z_in   = 1'b1;
        alu_op = 4'd0;
      end
      S_T1: begin
        zlow_out = 1'b1;
        pc_in    = 1'b1;
        read     = 1'b1;
        mdr_in   = 1'b1;
      end
      S_T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
      end
      S_T3: begin
        r_out = f_onehot(r_rb);
        y_in  = 1'b1;
      end
      S_T4: begin
        r_out  = f_onehot(r_rc);
        z_in   = 1'b1;
        alu_op = f_alu(r_opcode);
      end
      S_T5: begin
        zlow_out = 1'b1;
        if (f_muldiv(r_opcode)) begin
          lo_in = 1'b1;
        end else begin
          r_in = f_onehot(r_ra);
        end
      end
      S_T6: begin
        zhigh_out = 1'b1;
        hi_in     = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_bus_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bus_sequencer
// Directed bench for bus_sequencer. Stimulus pushes a hand-computed summary of
// each instruction's expected activity into a queue; an independent monitor
// accumulates what the DUT drives while busy and compares on the done pulse.
// The monitor also checks the bus-source invariant every cycle.
// -----------------------------------------------------------------------------
module tb_bus_sequencer;

  logic        clock;
  logic        clear;
  logic        start;
  logic [31:0] ir;
  logic        mem_ready;
  logic [15:0] r_out;
  logic        hi_out, lo_out, zhigh_out, zlow_out, pc_out, mdr_out, inport_out, y_out;
  logic [15:0] r_in;
  logic        hi_in, lo_in, y_in, z_in, pc_in, ir_in, mar_in, mdr_in;
  logic        inc_pc, read;
  logic [3:0]  alu_op;
  logic        busy, done;
  logic [1:0]  fault;

  bus_sequencer #(.OPW(5), .MEM_WAIT_MAX(15)) dut (
    .clock(clock), .clear(clear), .start(start), .ir(ir), .mem_ready(mem_ready),
    .r_out(r_out), .hi_out(hi_out), .lo_out(lo_out), .zhigh_out(zhigh_out),
    .zlow_out(zlow_out), .pc_out(pc_out), .mdr_out(mdr_out), .inport_out(inport_out),
    .y_out(y_out), .r_in(r_in), .hi_in(hi_in), .lo_in(lo_in), .y_in(y_in),
    .z_in(z_in), .pc_in(pc_in), .ir_in(ir_in), .mar_in(mar_in), .mdr_in(mdr_in),
    .inc_pc(inc_pc), .read(read), .alu_op(alu_op), .busy(busy), .done(done),
    .fault(fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          lat;
    logic [1:0]  flt;
    logic [15:0] rin;
    logic [15:0] rbm;
    logic [15:0] rcm;
    logic [3:0]  op;
    int          lo;
    int          hi;
    int          rd;
    int          irn;
    int          zn;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic exp_t mk(input int lat, input logic [1:0] flt, input logic [15:0] rin,
                              input logic [15:0] rbm, input logic [15:0] rcm,
                              input logic [3:0] op, input int lo, input int hi,
                              input int rd, input int irn, input int zn);
    exp_t e;
    e.lat = lat; e.flt = flt; e.rin = rin; e.rbm = rbm; e.rcm = rcm; e.op = op;
    e.lo = lo; e.hi = hi; e.rd = rd; e.irn = irn; e.zn = zn;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {6'd0, r_out, hi_out, lo_out, zhigh_out, zlow_out, pc_out, mdr_out,
            inport_out, y_out, r_in, hi_in, lo_in, y_in, z_in, pc_in, ir_in, mar_in,
            mdr_in, inc_pc, read, alu_op, busy, done, fault};
  endfunction

  // ---------------- monitor ----------------
  int          m_cyc, m_lo, m_hi, m_rd, m_irn, m_zn, m_src;
  logic [15:0] m_rin, m_rb, m_rc;
  logic [3:0]  m_op;

  task automatic m_clear_acc();
    m_cyc = 0; m_lo = 0; m_hi = 0; m_rd = 0; m_irn = 0; m_zn = 0;
    m_rin = 16'h0; m_rb = 16'h0; m_rc = 16'h0; m_op = 4'd0;
  endtask

  initial m_clear_acc();

  always @(negedge clock) begin
    if (!clear) begin
      m_clear_acc();
    end else begin
      m_src = $countones(r_out) + int'(hi_out) + int'(lo_out) + int'(zhigh_out) +
              int'(zlow_out) + int'(pc_out) + int'(mdr_out) + int'(inport_out) + int'(y_out);
      chk("bus_src_count", 64'(m_src), (busy && !done) ? 64'd1 : 64'd0);
      if (busy) begin
        m_cyc++;
        m_rin |= r_in;
        if (y_in) m_rb |= r_out;
        if (z_in && !pc_out) begin
          m_rc |= r_out;
          m_op = alu_op;
        end
        m_lo += int'(lo_in);
        m_hi += int'(hi_in);
        m_rd += int'(read);
        m_irn += int'(ir_in);
        m_zn += int'(z_in);
        if (done) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("latency", 64'(m_cyc), 64'(e.lat));
            chk("fault", 64'(fault), 64'(e.flt));
            chk("r_in_mask", 64'(m_rin), 64'(e.rin));
            chk("rb_mask", 64'(m_rb), 64'(e.rbm));
            chk("rc_mask", 64'(m_rc), 64'(e.rcm));
            chk("alu_op_t4", 64'(m_op), 64'(e.op));
            chk("lo_in_cnt", 64'(m_lo), 64'(e.lo));
            chk("hi_in_cnt", 64'(m_hi), 64'(e.hi));
            chk("read_cnt", 64'(m_rd), 64'(e.rd));
            chk("ir_in_cnt", 64'(m_irn), 64'(e.irn));
            chk("z_in_cnt", 64'(m_zn), 64'(e.zn));
          end
          m_clear_acc();
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Waits for done, answering memory reads after dly T1 cycles (dly<0: never).
  task automatic wait_done(input int dly);
    int  t1;
    bit  seen;
    t1   = 0;
    seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clock);
      if (read) begin
        mem_ready = (dly >= 0) && (t1 >= dly);
        t1++;
      end else begin
        mem_ready = 1'b0;
      end
      if (done) seen = 1'b1;
    end
    mem_ready = 1'b0;
    if (!seen) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_instr(input logic [31:0] w, input int dly, input exp_t e);
    sb_q.push_back(e);
    ir    = w;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    wait_done(dly);
    @(negedge clock);
  endtask

  initial begin
    bit hit;
    clear     = 1'b0;
    start     = 1'b0;
    ir        = 32'h0;
    mem_ready = 1'b0;
    #1;
    chk("reset_outputs", all_outs(), 64'd0);
    repeat (2) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    chk("idle_busy", 64'(busy), 64'd0);

    // ADD R1,R2,R3
    run_instr(32'h18918000, 0, mk(7, 2'b00, 16'h0002, 16'h0004, 16'h0008, 4'd0, 0, 0, 1, 1, 2));
    // MUL R0,R5,R6
    run_instr(32'h782B0000, 0, mk(8, 2'b00, 16'h0000, 16'h0020, 16'h0040, 4'd4, 1, 1, 1, 1, 2));
    // SUB R15,R0,R15 with three wait cycles in T1
    run_instr(32'h27878000, 3, mk(10, 2'b00, 16'h8000, 16'h0001, 16'h8000, 4'd1, 0, 0, 4, 1, 2));
    // Memory never ready: timeout after 15 T1 cycles, no IR load
    run_instr(32'h18918000, -1, mk(17, 2'b10, 16'h0000, 16'h0000, 16'h0000, 4'd0, 0, 0, 15, 0, 1));
    chk("timeout_sticky", 64'(fault), 64'd2);
    // Illegal opcode 11111 (rb=0 still driven in T3)
    run_instr(32'hF8000000, 0, mk(5, 2'b01, 16'h0000, 16'h0001, 16'h0000, 4'd0, 0, 0, 1, 1, 1));
    chk("illegal_sticky", 64'(fault), 64'd1);
    // DIV R7,R7,R7 with one wait cycle; fault cleared by the accepted start
    run_instr(32'h83BB8000, 1, mk(9, 2'b00, 16'h0000, 16'h0080, 16'h0080, 4'd5, 1, 1, 2, 1, 2));

    // start held high: OR R10,R11,R12 then AND R0,R1,R0 with one IDLE cycle between
    sb_q.push_back(mk(7, 2'b00, 16'h0400, 16'h0800, 16'h1000, 4'd3, 0, 0, 1, 1, 2));
    sb_q.push_back(mk(7, 2'b00, 16'h0001, 16'h0002, 16'h0001, 4'd2, 0, 0, 1, 1, 2));
    ir    = 32'h355E0000;
    start = 1'b1;
    @(posedge clock);
    wait_done(0);
    ir = 32'h28080000;
    @(negedge clock);
    chk("held_start_idle", 64'(busy), 64'd0);
    @(negedge clock);
    chk("held_start_t0", 64'({busy, pc_out}), 64'd3);
    wait_done(0);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("no_extra_start", 64'(busy), 64'd0);

    // Asynchronous clear in T4 of ADD R1,R2,R3
    ir        = 32'h18918000;
    mem_ready = 1'b1;
    start     = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clock);
      if (z_in && (r_out == 16'h0008)) hit = 1'b1;
    end
    chk("reach_t4", 64'(hit), 64'd1);
    #1 clear = 1'b0;
    #1;
    chk("clear_mid_t4", all_outs(), 64'd0);
    mem_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    chk("post_clear_idle", 64'(busy), 64'd0);
    run_instr(32'h18918000, 0, mk(7, 2'b00, 16'h0002, 16'h0004, 16'h0008, 4'd0, 0, 0, 1, 1, 2));

    repeat (3) @(negedge clock);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
